// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready on both sides, optional 2-entry
// skid buffer, synchronous flush to a bubble payload, saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned        WIDTH      = 32,
  parameter logic [WIDTH-1:0]   BUBBLE_VAL = '0,
  parameter bit                 SKID       = 1'b1,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             bubble_o,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             ready_raw;
  logic             accept;
  logic             emit;

  assign out_valid_o = (state != S_EMPTY);
  assign bubble_o    = ~out_valid_o;
  assign occupancy_o = state;
  assign data_o      = main_q;
  assign stall_cnt_o = stall_cnt;

  // With the skid buffer, ready depends only on registered state, breaking
  // the combinational back-pressure path from out_ready_i.
  if (SKID) begin : g_skid
    assign ready_raw = (state != S_TWO);
  end else begin : g_noskid
    assign ready_raw = ~out_valid_o | out_ready_i;
  end

  assign in_ready_o = ready_raw & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  assign emit       = out_valid_o & out_ready_i;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush_i) begin
      state_nxt = S_EMPTY;
      main_nxt  = BUBBLE_VAL;
      skid_nxt  = BUBBLE_VAL;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_ONE;
            main_nxt  = data_i;
          end
        end
        S_ONE: begin
          if (accept && emit) begin
            main_nxt = data_i;
          end else if (accept && SKID) begin
            state_nxt = S_TWO;
            skid_nxt  = data_i;
          end else if (emit) begin
            state_nxt = S_EMPTY;
            main_nxt  = BUBBLE_VAL;
          end
        end
        S_TWO: begin
          if (emit) begin
            state_nxt = S_ONE;
            main_nxt  = skid_q;
            skid_nxt  = BUBBLE_VAL;
          end
        end
        default: begin
          state_nxt = S_EMPTY;
          main_nxt  = BUBBLE_VAL;
          skid_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_EMPTY;
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
